// File: rtl/types_pkg.sv
// types_pkg: shared types and RV32I load/store size encodings for the LSU.
package types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DRAIN
    } lsu_state_t;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        MISALIGNED = 2'd1,
        ILLEGAL    = 2'd2,
        TIMEOUT    = 2'd3
    } lsu_err_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: request decode (legality, byte enables, lane-replicated store data)
// and load-side byte/half extraction with sign or zero extension.
module lsu_align import types_pkg::*; (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [15:0] half;

    always_comb begin
        illegal    = we ? (funct3 > F3_W) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misaligned = (funct3[1:0] == F3_H[1:0] && off[0]) || (funct3[1:0] == F3_W[1:0] && off != 2'b00);
        be         = !we ? 4'b1111
                   : funct3[1:0] == F3_B[1:0] ? 4'b0001 << off
                   : funct3[1:0] == F3_H[1:0] ? 4'b0011 << off
                   : 4'b1111;
        lane_wdata = funct3[1:0] == F3_B[1:0] ? {4{wdata[7:0]}}
                   : funct3[1:0] == F3_H[1:0] ? {2{wdata[15:0]}}
                   : wdata;
        // Only legal, aligned loads reach here, so the half never straddles the word.
        half       = 16'(rdata >> {ld_off, 3'b000});
        ld_data    = ld_funct3 == F3_W ? rdata
                   : ld_funct3[0] ? {{16{~ld_funct3[2] & half[15]}}, half}
                   : {{24{~ld_funct3[2] & half[7]}}, half[7:0]};
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit driving a word-addressed req/gnt/rvalid
// data-memory port, with alignment, illegal-size and timeout error reporting.
module lsu_mem_ctrl import types_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    lsu_state_t            state, state_d;
    lsu_err_t              err_q, err_d;
    logic [CW-1:0]         cnt;
    logic                  drain, drain_d, timed_out;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q, be;
    logic [31:0]           wdata_q, lane_wdata, ld_data, rdata_q, rdata_d;
    logic                  illegal, misaligned;

    lsu_align u_align (
        .we         (req_we),
        .funct3     (req_funct3),
        .off        (req_addr[1:0]),
        .wdata      (req_wdata),
        .illegal    (illegal),
        .misaligned (misaligned),
        .be         (be),
        .lane_wdata (lane_wdata),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .rdata      (mem_rdata),
        .ld_data    (ld_data)
    );

    assign timed_out = cnt >= CW'(TIMEOUT_CYCLES);
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign mem_req   = state == REQ;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state;
        err_d   = OK;
        rdata_d = '0;
        drain_d = drain;
        case (state)
            IDLE: begin
                drain_d = 1'b0;
                if (req_valid) begin
                    state_d = (illegal || misaligned) ? RESP : REQ;
                    err_d   = illegal ? ILLEGAL : misaligned ? MISALIGNED : OK;
                end
            end
            REQ: begin
                state_d = mem_gnt ? WAIT : timed_out ? RESP : REQ;
                err_d   = TIMEOUT;
            end
            WAIT: begin
                // A granted request still owes a response, so a timeout here must drain it.
                state_d = (mem_rvalid || timed_out) ? RESP : WAIT;
                err_d   = mem_rvalid ? OK : TIMEOUT;
                rdata_d = (mem_rvalid && !we_q) ? ld_data : '0;
                drain_d = !mem_rvalid && timed_out;
            end
            RESP:    state_d = (drain && !mem_rvalid) ? DRAIN : IDLE;
            DRAIN:   state_d = mem_rvalid ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            drain   <= 1'b0;
            cnt     <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= OK;
            rdata_q <= '0;
        end else begin
            state <= state_d;
            drain <= drain_d;
            cnt   <= (state != REQ && state_d == REQ) ? '0
                   : (state == REQ || state == WAIT) ? cnt + CW'(1)
                   : cnt;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                be_q    <= be;
                wdata_q <= req_we ? lane_wdata : '0;
            end
            if (state != RESP && state_d == RESP) begin
                err_q   <= err_d;
                rdata_q <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed vectors against hand-computed results for the LSU,
// driving a hand-sequenced memory port.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        issue(we, f3, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_mreq"}, mem_req, 1);
        check({tag, "_maddr"}, mem_addr, exp_addr);
        check({tag, "_mbe"}, mem_be, exp_be);
        check({tag, "_mwe"}, mem_we, we);
        if (we) check({tag, "_mwdata"}, mem_wdata, exp_wdata);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check({tag, "_mreq_drop"}, mem_req, 0);
        for (int i = 1; i < k; i++) begin
            @(negedge clk);
            check({tag, "_early"}, rsp_valid, 0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check({tag, "_rvalid"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, rsp_err, 0);
        @(negedge clk);
        check({tag, "_pulse"}, rsp_valid, 0);
        check({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic err_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exp_err);
        issue(we, f3, addr, 32'h0000_00FF);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_rvalid"}, rsp_valid, 1);
        check({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_rdata"}, rsp_rdata, 0);
        check({tag, "_nomreq"}, mem_req, 0);
        repeat (2) begin
            @(negedge clk);
            check({tag, "_pulse"}, rsp_valid, 0);
            check({tag, "_nomreq2"}, mem_req, 0);
            check({tag, "_hold"}, rsp_err, exp_err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal;
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_mreq", mem_req, 0);
        check("rst_rvalid", rsp_valid, 0);
        check("rst_err", rsp_err, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_mbe", mem_be, 0);
        check("rst_maddr", mem_addr, 0);
        rst_n = 1'b1;

        txn("sw",  1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0,         32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
        txn("sb",  1, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0,         32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
        txn("sh",  1, 3'b001, 32'h102, 32'h00001234, 1, 32'h0,         32'h100, 4'b1100, 32'h12341234, 32'h0);
        txn("lb",  0, 3'b000, 32'h102, 32'h0,        1, 32'h00800000,  32'h100, 4'b1111, 32'h0,        32'hFFFFFF80);
        txn("lbu", 0, 3'b100, 32'h102, 32'h0,        3, 32'h00800000,  32'h100, 4'b1111, 32'h0,        32'h00000080);
        txn("lh",  0, 3'b001, 32'h102, 32'h0,        1, 32'h80010000,  32'h100, 4'b1111, 32'h0,        32'hFFFF8001);
        txn("lhu", 0, 3'b101, 32'h102, 32'h0,        2, 32'h80010000,  32'h100, 4'b1111, 32'h0,        32'h00008001);
        txn("lw",  0, 3'b010, 32'h104, 32'h0,        1, 32'h12345678,  32'h104, 4'b1111, 32'h0,        32'h12345678);

        err_txn("lh_mis", 0, 3'b001, 32'h101, 2'd1);
        err_txn("lw_mis", 0, 3'b010, 32'h102, 2'd1);
        err_txn("ld_ill", 0, 3'b011, 32'h100, 2'd2);
        err_txn("st_ill", 1, 3'b100, 32'h100, 2'd2);

        // Granted, response withheld: timeout then drain until the late response.
        issue(1, 3'b010, 32'h200, 32'h11111111);
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("to_seen", rsp_valid, 1);
        check("to_err", rsp_err, 3);
        check("to_rdata", rsp_rdata, 0);
        repeat (3) begin
            @(negedge clk);
            check("to_drain_busy", req_ready, 0);
            check("to_drain_norsp", rsp_valid, 0);
        end
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("to_drain_done", req_ready, 1);
        check("to_drain_norsp2", rsp_valid, 0);

        // Never granted: timeout straight back to idle.
        issue(0, 3'b010, 32'h300, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ng_seen", rsp_valid, 1);
        check("ng_err", rsp_err, 3);
        check("ng_mreq", mem_req, 0);
        @(negedge clk);
        check("ng_ready", req_ready, 1);

        // Reset while the request is being presented.
        issue(0, 3'b010, 32'h400, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("rq_mreq", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("rq_rst_mreq", mem_req, 0);
        check("rq_rst_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while waiting; a stale response afterwards must be ignored.
        issue(0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("wt_busy", req_ready, 0);
        rst_n = 1'b0;
        #1;
        check("wt_rst_mreq", mem_req, 0);
        check("wt_rst_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            check("wt_stale_norsp", rsp_valid, 0);
            check("wt_stale_ready", req_ready, 1);
        end

        txn("post", 0, 3'b000, 32'h601, 32'h0, 1, 32'h00007F00, 32'h600, 4'b1111, 32'h0, 32'h0000007F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
